// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide memory bus initiator serving instruction fetch and load/store
module mem_ctrl #(
    parameter int IO_SEL_HI = 17
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    output logic [31:0] if_data_out,
    input  logic        ls_req_in,
    input  logic        ls_we_in,
    input  logic [1:0]  ls_size_in,
    input  logic [31:0] ls_addr_in,
    input  logic [31:0] ls_wdata_in,
    output logic        ls_done_out,
    output logic [31:0] ls_rdata_out,
    input  logic        flush_in
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;        // start address of the current access
    logic [31:0] wdata_q, wdata_d;      // store data latched at acceptance
    logic [31:0] data_q, data_d;        // read data being assembled
    logic [2:0]  len_q, len_d;          // bytes in the access (1/2/4)
    logic [2:0]  iss_q, iss_d;          // read: bytes issued; write: index of byte on the bus
    logic [2:0]  cap_q, cap_d;          // read: bytes captured so far
    logic        pend_q, pend_d;        // address on the bus this cycle is a live read
    logic        infl_q, infl_d;        // mem_din this cycle answers last cycle's read
    logic        is_if_q, is_if_d;      // current transaction belongs to instruction fetch
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_data_q, ls_data_d;

    logic [2:0]  ls_len;
    logic        is_io_store;
    logic        io_block;
    logic        can_accept;
    logic [2:0]  cap_n;
    logic [31:0] data_n;
    logic [2:0]  iss_n;

    assign is_io_store = ls_we_in && (ls_addr_in[IO_SEL_HI:IO_SEL_HI-1] == 2'b11);
    // A store to a full I/O FIFO stalls the whole arbiter, including a waiting fetch.
    assign io_block    = ls_req_in && is_io_store && io_buffer_full;
    // No acceptance while paused or while a done pulse is on the outputs.
    assign can_accept  = rdy_in && !if_done_q && !ls_done_q;

    // Decode load/store size into a byte count; size 11 behaves as a word.
    always_comb begin
        ls_len = 3'd4;
        case (ls_size_in)
            2'b00:   ls_len = 3'd1;
            2'b01:   ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/READ/WRITE sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        len_d      = len_q;
        iss_d      = iss_q;
        cap_d      = cap_q;
        pend_d     = pend_q;
        infl_d     = infl_q;
        is_if_d    = is_if_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_data_d  = ls_data_q;
        cap_n      = cap_q;
        data_n     = data_q;
        iss_n      = iss_q + 3'd1;

        case (state_q)
            IDLE: begin
                mem_wr_d = 1'b0;
                if (can_accept && ls_req_in && !io_block) begin
                    addr_d  = ls_addr_in;
                    len_d   = ls_len;
                    is_if_d = 1'b0;
                    mem_a_d = ls_addr_in;
                    data_d  = 32'd0;
                    cap_d   = 3'd0;
                    infl_d  = 1'b0;
                    if (ls_we_in) begin
                        state_d    = WRITE;
                        wdata_d    = ls_wdata_in;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = ls_wdata_in[7:0];
                        iss_d      = 3'd0;
                        pend_d     = 1'b0;
                    end else begin
                        state_d = READ;
                        iss_d   = 3'd1;
                        pend_d  = 1'b1;
                    end
                end else if (can_accept && !ls_req_in && if_req_in && !flush_in) begin
                    state_d = READ;
                    addr_d  = if_addr_in;
                    len_d   = 3'd4;
                    is_if_d = 1'b1;
                    mem_a_d = if_addr_in;
                    data_d  = 32'd0;
                    cap_d   = 3'd0;
                    iss_d   = 3'd1;
                    pend_d  = 1'b1;
                    infl_d  = 1'b0;
                end
            end

            READ: begin
                mem_wr_d = 1'b0;
                if (is_if_q && flush_in) begin
                    // Fetch abandoned: drop partial data, no done pulse.
                    state_d = IDLE;
                    pend_d  = 1'b0;
                    infl_d  = 1'b0;
                end else if (!rdy_in) begin
                    // Paused: anything in flight is lost, so park the bus on the
                    // first uncaptured byte; it counts as issued once rdy returns.
                    infl_d  = 1'b0;
                    pend_d  = 1'b1;
                    mem_a_d = addr_q + {29'd0, cap_q};
                    iss_d   = cap_q + 3'd1;
                end else begin
                    if (infl_q) begin
                        data_n[{cap_q[1:0], 3'b000} +: 8] = mem_din;
                        cap_n = cap_q + 3'd1;
                    end
                    infl_d = pend_q;
                    if (iss_q < len_q) begin
                        mem_a_d = addr_q + {29'd0, iss_q};
                        iss_d   = iss_q + 3'd1;
                        pend_d  = 1'b1;
                    end else begin
                        pend_d = 1'b0;
                    end
                    cap_d  = cap_n;
                    data_d = data_n;
                    if (cap_n == len_q) begin
                        state_d = IDLE;
                        pend_d  = 1'b0;
                        infl_d  = 1'b0;
                        if (is_if_q) begin
                            if_done_d = 1'b1;
                            if_data_d = data_n;
                        end else begin
                            ls_done_d = 1'b1;
                            ls_data_d = data_n;
                        end
                    end
                end
            end

            WRITE: begin
                if (!rdy_in) begin
                    // The byte on the bus is not counted as written; it is
                    // re-driven with the same data after the pause.
                    mem_wr_d = 1'b0;
                end else if (mem_wr_q) begin
                    if (iss_n == len_q) begin
                        state_d   = IDLE;
                        mem_wr_d  = 1'b0;
                        ls_done_d = 1'b1;
                    end else begin
                        iss_d      = iss_n;
                        mem_a_d    = addr_q + {29'd0, iss_n};
                        mem_dout_d = wdata_q[{iss_n[1:0], 3'b000} +: 8];
                        mem_wr_d   = 1'b1;
                    end
                end else begin
                    mem_wr_d = 1'b1;
                end
            end

            default: begin
                state_d  = IDLE;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            data_q     <= 32'd0;
            len_q      <= 3'd0;
            iss_q      <= 3'd0;
            cap_q      <= 3'd0;
            pend_q     <= 1'b0;
            infl_q     <= 1'b0;
            is_if_q    <= 1'b0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            len_q      <= len_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
            pend_q     <= pend_d;
            infl_q     <= infl_d;
            is_if_q    <= is_if_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_data_q  <= ls_data_d;
        end
    end

    assign mem_a        = mem_a_q;
    assign mem_dout     = mem_dout_q;
    assign mem_wr       = mem_wr_q;
    assign if_done_out  = if_done_q;
    assign if_data_out  = if_data_q;
    assign ls_done_out  = ls_done_q;
    assign ls_rdata_out = ls_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        ls_req_in;
    logic        ls_we_in;
    logic [1:0]  ls_size_in;
    logic [31:0] ls_addr_in;
    logic [31:0] ls_wdata_in;
    logic        ls_done_out;
    logic [31:0] ls_rdata_out;
    logic        flush_in;

    logic [7:0]  ram [0:65535];
    logic        pl_we;
    logic [15:0] pl_a;
    logic [7:0]  pl_d;
    int          io_wr_cnt;
    logic [7:0]  io_last;

    int vectors     = 0;
    int miscompares = 0;
    int n;

    mem_ctrl #(.IO_SEL_HI(17)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req_in     (if_req_in),
        .if_addr_in    (if_addr_in),
        .if_done_out   (if_done_out),
        .if_data_out   (if_data_out),
        .ls_req_in     (ls_req_in),
        .ls_we_in      (ls_we_in),
        .ls_size_in    (ls_size_in),
        .ls_addr_in    (ls_addr_in),
        .ls_wdata_in   (ls_wdata_in),
        .ls_done_out   (ls_done_out),
        .ls_rdata_out  (ls_rdata_out),
        .flush_in      (flush_in)
    );

    always #5 clk_in = ~clk_in;

    // RAM with 1-cycle read latency plus an I/O write sink at region 2'b11.
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[15:0]];
        if (pl_we) begin
            ram[pl_a] <= pl_d;
        end else if (mem_wr && rdy_in) begin
            if (mem_a[17:16] == 2'b11) begin
                io_wr_cnt <= io_wr_cnt + 1;
                io_last   <= mem_dout;
            end else begin
                ram[mem_a[15:0]] <= mem_dout;
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        step();
        pl_we = 1'b0;
    endtask

    task automatic wait_done(input bit ls, input int maxc, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (((ls ? ls_done_out : if_done_out) !== 1'b1) && cnt < maxc);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; flush_in = 1'b0;
        if_req_in = 1'b0; if_addr_in = 32'd0;
        ls_req_in = 1'b0; ls_we_in = 1'b0; ls_size_in = 2'b00;
        ls_addr_in = 32'd0; ls_wdata_in = 32'd0;
        pl_we = 1'b0; pl_a = 16'd0; pl_d = 8'd0;
        io_wr_cnt = 0; io_last = 8'd0;
        step();
        poke(16'h1000, 8'h13); poke(16'h1001, 8'h05);
        poke(16'h1002, 8'h00); poke(16'h1003, 8'h00);
        poke(16'h0010, 8'h80);
        poke(16'h2002, 8'h22); poke(16'h2005, 8'h44);
        poke(16'h3000, 8'h00); poke(16'h3001, 8'h77);

        // Reset state
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
        chk("rst_dout", {24'd0, mem_dout}, 32'h0);
        chk("rst_dones", {30'd0, if_done_out, ls_done_out}, 32'h0);
        chk("rst_data", if_data_out | ls_rdata_out, 32'h0);
        rst_in = 1'b1;
        step();

        // IF fetch at 0x1000
        if_req_in = 1'b1; if_addr_in = 32'h0000_1000;
        step(); chk("if_c1_a", mem_a, 32'h1000); chk("if_c1_wr", {31'd0, mem_wr}, 32'h0);
        step(); chk("if_c2_a", mem_a, 32'h1001);
        step(); chk("if_c3_a", mem_a, 32'h1002);
        step(); chk("if_c4_a", mem_a, 32'h1003);
        step(); chk("if_c5_nodone", {31'd0, if_done_out}, 32'h0);
        step(); chk("if_c6_done", {31'd0, if_done_out}, 32'h1);
        chk("if_data", if_data_out, 32'h0000_0513);
        if_req_in = 1'b0;
        step(); chk("if_done_pulse", {31'd0, if_done_out}, 32'h0);

        // LS store half, misaligned, at 0x2003
        ls_req_in = 1'b1; ls_we_in = 1'b1; ls_size_in = 2'b01;
        ls_addr_in = 32'h0000_2003; ls_wdata_in = 32'h1234_BEEF;
        step(); chk("st_c1", {mem_wr, 7'd0, mem_dout, mem_a[15:0]}, {1'b1, 7'd0, 8'hEF, 16'h2003});
        step(); chk("st_c2", {mem_wr, 7'd0, mem_dout, mem_a[15:0]}, {1'b1, 7'd0, 8'hBE, 16'h2004});
        step(); chk("st_c3_done", {30'd0, mem_wr, ls_done_out}, 32'h1);
        ls_req_in = 1'b0; ls_we_in = 1'b0;
        step();

        // Word load read-back at 0x2002 spanning the stored bytes
        ls_req_in = 1'b1; ls_size_in = 2'b10; ls_addr_in = 32'h0000_2002;
        wait_done(1'b1, 20, n);
        chk("ldw_latency", n, 6);
        chk("ldw_data", ls_rdata_out, 32'h44BE_EF22);
        ls_req_in = 1'b0;
        step();

        // Simultaneous IF + LS byte load: LS first
        ls_req_in = 1'b1; ls_size_in = 2'b00; ls_addr_in = 32'h0000_0010;
        if_req_in = 1'b1; if_addr_in = 32'h0000_1000;
        step(); chk("arb_c1_a", mem_a, 32'h10);
        wait_done(1'b1, 20, n);
        chk("arb_ls_latency", n, 2);
        chk("arb_ls_data", ls_rdata_out, 32'h0000_0080);
        ls_req_in = 1'b0;
        wait_done(1'b0, 20, n);
        chk("arb_if_latency", n, 7);
        chk("arb_if_data", if_data_out, 32'h0000_0513);
        if_req_in = 1'b0;
        step();

        // Flush at C3 of a fetch, then a fresh fetch at 0x2002
        if_req_in = 1'b1; if_addr_in = 32'h0000_1000;
        step(); step(); step();
        flush_in = 1'b1;
        step(); chk("fl_nodone", {31'd0, if_done_out}, 32'h0);
        flush_in = 1'b0; if_addr_in = 32'h0000_2002;
        step(); chk("fl_restart_a", mem_a, 32'h2002);
        wait_done(1'b0, 20, n);
        chk("fl_if_latency", n, 5);
        chk("fl_if_data", if_data_out, 32'h44BE_EF22);
        if_req_in = 1'b0;
        step();

        // I/O store blocked by full FIFO, with a fetch waiting behind it
        ls_req_in = 1'b1; ls_we_in = 1'b1; ls_size_in = 2'b00;
        ls_addr_in = 32'h0003_0000; ls_wdata_in = 32'h0000_005A;
        io_buffer_full = 1'b1;
        if_req_in = 1'b1; if_addr_in = 32'h0000_1000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("io_blk_wr", {31'd0, mem_wr}, 32'h0);
            chk("io_blk_a", mem_a, 32'h2005);
        end
        io_buffer_full = 1'b0;
        step(); chk("io_c1", {mem_wr, 7'd0, mem_dout, mem_a[15:0]}, {1'b1, 7'd0, 8'h5A, 16'h0000});
        chk("io_c1_ahi", mem_a, 32'h0003_0000);
        step(); chk("io_done", {31'd0, ls_done_out}, 32'h1);
        ls_req_in = 1'b0; ls_we_in = 1'b0;
        wait_done(1'b0, 20, n);
        chk("io_if_latency", n, 7);
        chk("io_if_data", if_data_out, 32'h0000_0513);
        chk("io_wr_cnt", io_wr_cnt, 1);
        chk("io_last", {24'd0, io_last}, 32'h5A);
        if_req_in = 1'b0;
        step();

        // rdy_in low for 3 cycles at C3 of a word load
        ls_req_in = 1'b1; ls_size_in = 2'b10; ls_addr_in = 32'h0000_1000;
        step(); chk("pz_c1_a", mem_a, 32'h1000);
        step(); chk("pz_c2_a", mem_a, 32'h1001);
        step(); rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("pz_wr", {31'd0, mem_wr}, 32'h0);
            step();
        end
        rdy_in = 1'b1;
        chk("pz_redrive_a", mem_a, 32'h1001);
        wait_done(1'b1, 20, n);
        chk("pz_latency", n, 4);
        chk("pz_data", ls_rdata_out, 32'h0000_0513);
        ls_req_in = 1'b0;
        step();

        // Reset in the middle of a word store
        ls_req_in = 1'b1; ls_we_in = 1'b1; ls_size_in = 2'b10;
        ls_addr_in = 32'h0000_3000; ls_wdata_in = 32'hDDCC_BBAA;
        step(); chk("rs_c1", {mem_wr, 7'd0, mem_dout, mem_a[15:0]}, {1'b1, 7'd0, 8'hAA, 16'h3000});
        rst_in = 1'b0;
        step();
        chk("rs_mem_a", mem_a, 32'h0);
        chk("rs_wr_dout", {23'd0, mem_wr, mem_dout}, 32'h0);
        chk("rs_dones", {30'd0, if_done_out, ls_done_out}, 32'h0);
        chk("rs_if_data", if_data_out, 32'h0);
        chk("rs_ls_data", ls_rdata_out, 32'h0);
        rst_in = 1'b1; ls_req_in = 1'b0; ls_we_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rs_no_wr", {31'd0, mem_wr}, 32'h0);
        end
        chk("rs_ram_3001", {24'd0, ram[16'h3001]}, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
